// File: rtl/adder_arb_pkg.sv
// rtl/adder_arb_pkg.sv - shared constants, stage state encoding and id width helper
package adder_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int DATA_W  = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - shared W-bit ripple-carry adder, sum wraps modulo 2**W
module adder
  import adder_arb_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum
);

  always_comb begin
    logic c;
    c     = 1'b0;
    o_sum = '0;
    for (int i = 0; i < W; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ c;
      c        = (i_a[i] & i_b[i]) | (c & (i_a[i] ^ i_b[i]));
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant search starting at i_ptr, wrapping to 0
module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_enable,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_idx,
  output logic               o_any_grant
);

  always_comb begin
    logic [ID_W-1:0] v_idx;
    v_idx       = '0;
    o_grant     = '0;
    o_grant_idx = '0;
    o_any_grant = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      v_idx = ID_W'((int'(i_ptr) + i) % NUM_REQ);
      if (i_enable && !o_any_grant && i_req[v_idx]) begin
        o_grant[v_idx] = 1'b1;
        o_grant_idx    = v_idx;
        o_any_grant    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_share_arb.sv
// rtl/adder_share_arb.sv - shares one adder among NUM_REQ requesters through a one-entry stage
// ADDER_ARB_PRIO0_EN: requester 0 takes fixed priority over the round-robin search.
module adder_share_arb
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_op0,
  input  logic [NUM_REQ*DATA_W-1:0] req_op1,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_W-1:0]         resp_data,
  output logic [ID_W-1:0]           resp_id
);

  state_t              r_state, w_state_nxt;
  logic [ID_W-1:0]     r_rr_ptr, r_id;
  logic [DATA_W-1:0]   r_op0, r_op1, w_op0, w_op1, w_sum;
  logic [NUM_REQ-1:0]  w_arb_grant, w_grant;
  logic [ID_W-1:0]     w_arb_idx, w_grant_idx;
  logic                w_arb_any, w_accept, w_prio0, w_fire;

  assign w_accept = !rst && ((r_state == ST_EMPTY) || resp_ready);

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .i_req       (req_valid),
    .i_enable    (w_accept),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_arb_grant),
    .o_grant_idx (w_arb_idx),
    .o_any_grant (w_arb_any)
  );

`ifdef ADDER_ARB_PRIO0_EN
  assign w_prio0 = w_accept && req_valid[0];
`else
  assign w_prio0 = 1'b0;
`endif

  always_comb begin
    w_grant     = w_arb_grant;
    w_grant_idx = w_arb_idx;
    w_fire      = w_arb_any;
    if (w_prio0) begin
      w_grant     = NUM_REQ'(1);
      w_grant_idx = '0;
      w_fire      = 1'b1;
    end
  end

  always_comb begin
    w_op0 = '0;
    w_op1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_op0 = req_op0[i*DATA_W +: DATA_W];
        w_op1 = req_op1[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // A drain and a reload in the same cycle keep the stage FULL.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_fire) w_state_nxt = ST_FULL;
      ST_FULL: begin
        if (w_fire)          w_state_nxt = ST_FULL;
        else if (resp_ready) w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op0    <= '0;
      r_op1    <= '0;
      r_id     <= '0;
      r_rr_ptr <= '0;
    end else if (w_fire) begin
      r_op0 <= w_op0;
      r_op1 <= w_op1;
      r_id  <= w_grant_idx;
      if (!w_prio0) r_rr_ptr <= ID_W'((int'(w_grant_idx) + 1) % NUM_REQ);
    end
  end

  adder #(.W(DATA_W)) u_adder (
    .i_a   (r_op0),
    .i_b   (r_op1),
    .o_sum (w_sum)
  );

  // Outputs read zero for the whole reset cycle, even before the stage clears.
  assign req_ready  = w_grant;
  assign resp_valid = !rst && (r_state == ST_FULL);
  assign resp_data  = rst ? '0 : w_sum;
  assign resp_id    = rst ? '0 : r_id;

endmodule

// File: tb/tb_adder_share_arb.sv
// tb/tb_adder_share_arb.sv - directed and random checks of adder_share_arb against a behavioural model
module tb_adder_share_arb;

  localparam int N = 4;

  logic         clk, rst, resp_valid, resp_ready;
  logic [N-1:0] req_valid, req_ready;
  logic [N*8-1:0] req_op0, req_op1;
  logic [7:0]   resp_data;
  logic [1:0]   resp_id;

  logic [7:0] op0 [N];
  logic [7:0] op1 [N];
  logic [N-1:0] pend;

  int n_tests = 0;
  int n_fail  = 0;

  bit m_held;
  int m_sum, m_id, m_ptr;

  logic [N-1:0] o_rdy;
  logic         o_vld;
  logic [7:0]   o_dat;
  logic [1:0]   o_id;
  int           o_g;

  adder_share_arb #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner is the valid requester at the smallest forward distance from the pointer.
  function automatic int model_grant(input logic [N-1:0] v, input int ptr);
    int best, bestd, d;
    best  = -1;
    bestd = N;
`ifdef ADDER_ARB_PRIO0_EN
    if (v[0]) return 0;
`endif
    for (int i = 0; i < N; i++) begin
      d = (i - ptr + N) % N;
      if (v[i] && d < bestd) begin
        bestd = d;
        best  = i;
      end
    end
    return best;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      req_op0[i*8 +: 8] = op0[i];
      req_op1[i*8 +: 8] = op1[i];
    end
  endtask

  task automatic cycle(input logic [N-1:0] v, input logic rr);
    bit acc;
    logic [N-1:0] er;
    rst = 1'b0;
    req_valid = v;
    resp_ready = rr;
    drive_ops();
    #4;
    acc = !m_held || rr;
    o_g = acc ? model_grant(v, m_ptr) : -1;
    er  = (o_g >= 0) ? N'(1 << o_g) : '0;
    o_rdy = req_ready;
    o_vld = resp_valid;
    o_dat = resp_data;
    o_id  = resp_id;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("resp_valid", 32'(resp_valid), 32'(m_held));
    if (m_held) begin
      chk("resp_data", 32'(resp_data), 32'(m_sum));
      chk("resp_id", 32'(resp_id), 32'(m_id));
    end
    @(posedge clk);
    #1;
    if (o_g >= 0) begin
      m_held = 1'b1;
      m_sum  = (int'(op0[o_g]) + int'(op1[o_g])) % 256;
      m_id   = o_g;
`ifdef ADDER_ARB_PRIO0_EN
      if (o_g != 0) m_ptr = (o_g + 1) % N;
`else
      m_ptr = (o_g + 1) % N;
`endif
    end else if (m_held && rr) begin
      m_held = 1'b0;
    end
  endtask

  task automatic reset_cycle();
    rst = 1'b1;
    req_valid = '1;
    resp_ready = 1'b1;
    drive_ops();
    #4;
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_resp_valid", 32'(resp_valid), 32'(0));
    chk("rst_resp_data", 32'(resp_data), 32'(0));
    chk("rst_resp_id", 32'(resp_id), 32'(0));
    @(posedge clk);
    #1;
    m_held = 1'b0; m_sum = 0; m_id = 0; m_ptr = 0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; resp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin op0[i] = 8'h00; op1[i] = 8'h00; end
    req_op0 = '0; req_op1 = '0;
    m_held = 1'b0; m_sum = 0; m_id = 0; m_ptr = 0;

    reset_cycle();
    reset_cycle();

    op0[2] = 8'h12; op1[2] = 8'h34;
    cycle(4'b0100, 1'b0);
    chk("single_ready", 32'(o_rdy), 32'(4'b0100));
    cycle(4'b0000, 1'b1);
    chk("single_valid", 32'(o_vld), 32'(1));
    chk("single_data", 32'(o_dat), 32'(8'h46));
    chk("single_id", 32'(o_id), 32'(2));

    op0[1] = 8'hF0; op1[1] = 8'h20;
    cycle(4'b0010, 1'b1);
    cycle(4'b0000, 1'b1);
    chk("wrap_data", 32'(o_dat), 32'(8'h10));
    chk("wrap_id", 32'(o_id), 32'(1));

    reset_cycle();
    for (int k = 0; k < 8; k++) begin
      op0[k % N] = 8'(k * 17); op1[k % N] = 8'(k + 3);
      cycle(4'b1111, 1'b1);
`ifdef ADDER_ARB_PRIO0_EN
      chk("fair_grant", 32'(o_rdy), 32'(4'b0001));
`else
      chk("fair_grant", 32'(o_rdy), 32'(1 << (k % N)));
`endif
      if (k > 0) chk("fair_resp_valid", 32'(o_vld), 32'(1));
    end
    cycle(4'b0000, 1'b1);

    reset_cycle();
    op0[2] = 8'h12; op1[2] = 8'h34;
    op0[1] = 8'h05; op1[1] = 8'h06;
    cycle(4'b0100, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0010, 1'b0);
      chk("bp_ready", 32'(o_rdy), 32'(0));
      chk("bp_data", 32'(o_dat), 32'(8'h46));
      chk("bp_id", 32'(o_id), 32'(2));
    end
    cycle(4'b0010, 1'b1);
    chk("bp_drain_accept", 32'(o_rdy), 32'(4'b0010));
    chk("bp_drain_data", 32'(o_dat), 32'(8'h46));
    cycle(4'b0000, 1'b0);
    chk("bp_next_valid", 32'(o_vld), 32'(1));
    chk("bp_next_data", 32'(o_dat), 32'(8'h0B));
    chk("bp_next_id", 32'(o_id), 32'(1));

    cycle(4'b1000, 1'b1);
    cycle(4'b0000, 1'b0);
    reset_cycle();
    cycle(4'b1111, 1'b1);
    chk("post_rst_grant", 32'(o_rdy), 32'(4'b0001));
    chk("post_rst_valid", 32'(o_vld), 32'(0));
    cycle(4'b0000, 1'b1);

`ifdef ADDER_ARB_PRIO0_EN
    reset_cycle();
    for (int k = 0; k < 5; k++) begin
      cycle(4'b0101, 1'b1);
      chk("prio0_grant", 32'(o_rdy), 32'(4'b0001));
    end
    cycle(4'b0100, 1'b1);
    chk("prio0_release", 32'(o_rdy), 32'(4'b0100));
    cycle(4'b0000, 1'b1);
`endif

    reset_cycle();
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          op0[i]  = 8'($urandom);
          op1[i]  = 8'($urandom);
        end
      end
      cycle(pend, 1'($urandom_range(0, 3) != 0));
      if (o_g >= 0) pend[o_g] = 1'b0;
      if (c == 200) reset_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_share_arb.md
# adder_share_arb

Round-robin arbiter and sequencer that shares the single 8-bit ripple adder (`adder`) between up to NUM_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle and holds the operands in a one-entry stage register that feeds the adder. It returns the 8-bit sum, tagged with the requester index, on a valid/ready response port. It sits between the datapath clients and the shared adder, so the adder has exactly one driver.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..8.
- ID_W, $clog2(NUM_REQ): width of the requester index.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  bit i: requester i presents an operand pair.
- req_ready  output  NUM_REQ  bit i: requester i is accepted this cycle; one-hot or zero.
- req_op0  input  NUM_REQ*8  flattened operand0; requester i occupies bits [8i+7:8i].
- req_op1  input  NUM_REQ*8  flattened operand1, same packing as req_op0.
- resp_valid  output  1  resp_data and resp_id are valid.
- resp_ready  input  1  consumer accepts the response this cycle.
- resp_data  output  8  sum (op0 + op1) mod 256.
- resp_id  output  ID_W  index of the requester that owns resp_data.

## Operation
- Two-state FSM on the stage register:
  - EMPTY: no operation is held.
  - FULL: an operation is held and resp_valid=1.
- accept = (state==EMPTY) || (resp_ready). The stage is free this cycle, or it drains this cycle.
- Grant selection:
  - Search req_valid starting at rr_ptr, increasing index, wrapping at NUM_REQ-1 → 0.
  - The first set bit is the grant.
  - req_ready[grant] = accept && |req_valid. All other req_ready bits are 0.
- Request handshake: the handshake occurs when req_valid[i] && req_ready[i]. On that edge:
  - the stage latches op0, op1 and id=i;
  - state becomes FULL;
  - rr_ptr becomes (i+1) mod NUM_REQ.
- Draining: FULL && resp_ready with no new handshake → EMPTY.
- Simultaneous drain and accept: the stage is reloaded and the FSM stays FULL. Throughput is one operation per cycle.
- rr_ptr does not change when no grant occurs.
- Datapath:
  - The shared adder's operands come only from the stage register.
  - resp_data = adder output. resp_id = stored id.
  - Arithmetic wraps modulo 256. There is no carry-out or overflow flag.
- Response stability: while resp_valid=1 && resp_ready=0, resp_data and resp_id hold stable.
- Requester rule: a requester must hold req_valid and its operands until its handshake. The block does not check this rule.
- Reset:
  - While rst=1: state=EMPTY, rr_ptr=0, stage op0/op1/id = 0, resp_valid=0, resp_data=0, resp_id=0, req_ready=0.
  - Reset asserted mid-operation discards the held operation. No response is produced for it.

## Timing
- req_ready is combinational from req_valid, state, resp_ready and rr_ptr. It is gated to 0 during rst.
- Latency: a handshake on edge T gives resp_valid=1 from T to T+1, with the sum valid in the same cycle.
- resp_data is registered operands through the combinational ripple adder. It is not re-registered.
- With continuous resp_ready=1 and all requesters valid, grants rotate 0,1,2,3,0,… at one per cycle.
- With resp_ready=0 and state FULL, no req_ready is asserted.

## Configuration
- ADDER_ARB_PRIO0_EN defined:
  - Requester 0 has fixed highest priority. If req_valid[0] && accept, grant=0 regardless of rr_ptr.
  - A grant to 0 leaves rr_ptr unchanged.
  - All other requesters arbitrate round-robin as above.
- Not defined: pure round-robin across all NUM_REQ requesters. Requester 0 gets no special treatment.

## Structure
- Package adder_arb_pkg holds:
  - MAX_REQ=8 and DATA_W=8;
  - the state enum {ST_EMPTY, ST_FULL};
  - the ID width function.
- Sub-module rr_arbiter (NUM_REQ parameter):
  - inputs: req vector, enable, pointer;
  - outputs: one-hot grant, grant index, any_grant.
  - The priority override from ADDER_ARB_PRIO0_EN lives in the top level, not in rr_arbiter.
- The top level instantiates rr_arbiter and the existing `adder` once.

## Test plan
- Single request: reset, then req_valid=4'b0100, op0=8'h12, op1=8'h34 → req_ready=4'b0100 for one cycle. Next cycle resp_valid=1, resp_data=8'h46, resp_id=2.
- Wrap-around: requester 1 sends op0=8'hF0, op1=8'h20 → resp_data=8'h10, with no flag.
- Fairness: all four valid, resp_ready=1, 8 cycles → grant order 0,1,2,3,0,1,2,3, one response per cycle.
- Backpressure: stage FULL with resp_data=8'h46, resp_ready=0 for 3 cycles, another requester valid → req_ready=0 and resp_data/resp_id stable. When resp_ready=1, the drain and the new accept occur in the same cycle.
- Mid-operation reset: stage FULL with resp_ready=0, then rst=1 for one cycle → resp_valid=0, resp_data=0, rr_ptr=0. The first post-reset grant with all requesters valid goes to 0.
- ADDER_ARB_PRIO0_EN defined: requesters 0 and 2 valid continuously → grant is always 0. Requester 2 is granted only once req_valid[0] drops.
